// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: round-robin owner of a shared clock divider's factor input; acks each requester once its factor is in effect.
// Optional settle timeout is compiled in when CLK_DIV_CTRL_TIMEOUT_EN is defined.
module clk_div_ctrl #(
    parameter int DIV_FACTOR_WIDTH = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ*DIV_FACTOR_WIDTH-1:0] factor_i,
    output logic [NUM_REQ-1:0]                  ack_o,
    output logic                                busy_o,
    output logic [$clog2(NUM_REQ)-1:0]          owner_o,
    output logic [DIV_FACTOR_WIDTH-1:0]         div_factor_o,
    input  logic                                clk_div_i,
    output logic                                timeout_o
);
    localparam int W = DIV_FACTOR_WIDTH;
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, APPLY, SETTLE, ACK} state_t;
    state_t state;
    logic [IW-1:0] ptr, win, cand;
    logic any_req, clk_div_q, toggle, seen_toggle;
    logic [W-1:0] fac [NUM_REQ];
    logic [W-1:0] norm, n_q;
    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("clk_div_ctrl: parameter out of range");
    end
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fac
        assign fac[g] = factor_i[g*W +: W];
    end
    // Scan downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        win = ptr;
        cand = ptr;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % NUM_REQ);
            if (req_i[cand]) begin
                win = cand;
                any_req = 1'b1;
            end
        end
    end
    assign norm = (fac[win] < W'(2)) ? W'(2) : {fac[win][W-1:1], 1'b0};
    assign toggle = clk_div_i ^ clk_div_q;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`else
    assign timeout_o = 1'b0;
`endif
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr <= '0;
            owner_o <= '0;
            n_q <= W'(2);
            div_factor_o <= W'(2);
            ack_o <= '0;
            busy_o <= 1'b0;
            clk_div_q <= 1'b0;
            seen_toggle <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
            to_cnt <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
            clk_div_q <= clk_div_i;
            ack_o <= '0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_o <= win;
                        n_q <= norm;
                        busy_o <= 1'b1;
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    if (n_q == div_factor_o) begin
                        ack_o <= NUM_REQ'(1) << owner_o;
                        state <= ACK;
                    end else begin
                        div_factor_o <= n_q;
                        seen_toggle <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (toggle) seen_toggle <= 1'b1;
                    // Second edge proves a full half-period has run under the new factor.
                    if (toggle && seen_toggle) begin
                        ack_o <= NUM_REQ'(1) << owner_o;
                        state <= ACK;
                    end
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
                    else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        ack_o <= NUM_REQ'(1) << owner_o;
                        timeout_o <= 1'b1;
                        state <= ACK;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ACK: begin
                    ptr <= (owner_o == IW'(NUM_REQ - 1)) ? '0 : owner_o + 1'b1;
                    busy_o <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed self-checking bench for clk_div_ctrl; clk_div_i is driven by hand.
module tb_clk_div_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cdiv = 1'b0;
    logic [3:0] req = '0;
    logic [31:0] fac = '0;
    logic [3:0] ack;
    logic busy, tmo;
    logic [1:0] owner;
    logic [7:0] div;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(.DIV_FACTOR_WIDTH(8), .NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_i(req),
        .factor_i(fac),
        .ack_o(ack),
        .busy_o(busy),
        .owner_o(owner),
        .div_factor_o(div),
        .clk_div_i(cdiv),
        .timeout_o(tmo)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One grant-to-idle transaction for requester k; hold = quiet cycles between the two divider toggles.
    task automatic txn(input int k, input logic [7:0] exp_div, input bit settle, input int hold);
        cyc(1);
        chk($sformatf("grant%0d_owner", k), 32'(owner), 32'(k));
        chk($sformatf("grant%0d_busy", k), 32'(busy), 32'd1);
        chk($sformatf("grant%0d_noack", k), 32'(ack), 32'd0);
        cyc(1);
        chk($sformatf("apply%0d_div", k), 32'(div), 32'(exp_div));
        if (settle) begin
            chk($sformatf("settle%0d_noack", k), 32'(ack), 32'd0);
            cdiv = ~cdiv;
            cyc(1);
            chk($sformatf("toggle1_%0d_noack", k), 32'(ack), 32'd0);
            for (int h = 0; h < hold; h++) begin
                cyc(1);
                chk($sformatf("hold%0d_noack", k), 32'(ack), 32'd0);
            end
            cdiv = ~cdiv;
            cyc(1);
        end
        chk($sformatf("ack%0d", k), 32'(ack), 32'd1 << k);
        chk($sformatf("ack%0d_busy", k), 32'(busy), 32'd1);
        chk($sformatf("ack%0d_tmo", k), 32'(tmo), 32'd0);
        req[k] = 1'b0;
        cyc(1);
        chk($sformatf("post%0d_ack", k), 32'(ack), 32'd0);
        chk($sformatf("post%0d_busy", k), 32'(busy), 32'd0);
        chk($sformatf("post%0d_owner", k), 32'(owner), 32'(k));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_div", 32'(div), 32'd2);
        chk("rst_tmo", 32'(tmo), 32'd0);
        rst = 1'b0;
        // factor 0 normalizes to 2 == current: equal-factor path
        fac[23:16] = 8'd0;
        req[2] = 1'b1;
        txn(2, 8'd2, 1'b0, 0);
        // single request, half-period 5
        fac[15:8] = 8'd10;
        req[1] = 1'b1;
        txn(1, 8'd10, 1'b1, 4);
        // odd factor rounds down
        fac[7:0] = 8'd7;
        req[0] = 1'b1;
        txn(0, 8'd6, 1'b1, 0);
        // round robin from reset
        rst = 1'b1;
        req = '0;
        cdiv = 1'b0;
        cyc(2);
        rst = 1'b0;
        fac = {8'd10, 8'd8, 8'd6, 8'd4};
        req = 4'hf;
        for (int k = 0; k < 4; k++) txn(k, 8'(4 + 2 * k), 1'b1, 1);
        // pointer wrapped to 0 after requester 3
        fac = {8'd10, 8'd0, 8'd0, 8'd10};
        req = 4'b1001;
        txn(0, 8'd10, 1'b0, 0);
        txn(3, 8'd10, 1'b0, 0);
        // reset in the middle of SETTLE
        fac[15:8] = 8'd12;
        req[1] = 1'b1;
        cyc(1);
        cyc(1);
        chk("mid_div", 32'(div), 32'd12);
        cyc(1);
        rst = 1'b1;
        #1;
        chk("abort_div", 32'(div), 32'd2);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_owner", 32'(owner), 32'd0);
        cyc(2);
        chk("abort_hold_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        txn(1, 8'd12, 1'b1, 2);
        // divider stuck: timeout behaviour
        fac[23:16] = 8'd4;
        req[2] = 1'b1;
        cyc(1);
        chk("to_owner", 32'(owner), 32'd2);
        cyc(1);
        chk("to_div", 32'(div), 32'd4);
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        cyc(15);
        chk("to_early_ack", 32'(ack), 32'd0);
        chk("to_early_tmo", 32'(tmo), 32'd0);
        cyc(1);
        chk("to_ack", 32'(ack), 32'd4);
        chk("to_tmo", 32'(tmo), 32'd1);
        chk("to_div_kept", 32'(div), 32'd4);
        req[2] = 1'b0;
        cyc(1);
        chk("to_post_tmo", 32'(tmo), 32'd0);
        chk("to_post_busy", 32'(busy), 32'd0);
`else
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                cyc(1);
                if (ack !== 4'd0 || tmo !== 1'b0) seen = 1'b1;
            end
            chk("no_to_ack", 32'(seen), 32'd0);
        end
        chk("no_to_busy", 32'(busy), 32'd1);
        cdiv = ~cdiv;
        cyc(1);
        cdiv = ~cdiv;
        cyc(1);
        chk("late_ack", 32'(ack), 32'd4);
        chk("late_tmo", 32'(tmo), 32'd0);
        req[2] = 1'b0;
        cyc(1);
        chk("late_post_busy", 32'(busy), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Round-robin controller that shares one programmable clock divider among several requesters that each want a different divide factor. It arbitrates change requests, normalizes the factor to what the divider can realize, and drives the divider's factor input. It then watches the divided clock until the new factor is in effect and acknowledges the winning requester. It sits directly in front of the clock divider, in the same `clk_i` domain, and is the only agent allowed to drive its factor input.

## Interface
Parameters:
- `DIV_FACTOR_WIDTH`, 8: width of every factor bus; must match the divider.
- `NUM_REQ`, 4: number of requesters, range 2..16.
- `TIMEOUT_CYCLES`, 1024: settle timeout in `clk_i` cycles (used only with the timeout feature).

Ports:
- `clk_i`  in  1: system clock; divider runs on the same clock.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `req_i`  in  NUM_REQ: per-requester change request, level; held until its ack.
- `factor_i`  in  NUM_REQ*DIV_FACTOR_WIDTH: requested factor, slice n is requester n; stable while `req_i[n]` is high.
- `ack_o`  out  NUM_REQ: one-cycle completion pulse to the granted requester.
- `busy_o`  out  1: high in every state except IDLE.
- `owner_o`  out  $clog2(NUM_REQ): index of the current or last granted requester.
- `div_factor_o`  out  DIV_FACTOR_WIDTH: factor driven to the divider.
- `clk_div_i`  in  1: divided clock fed back from the divider (a `clk_i`-domain register, sampled directly, no synchronizer).
- `timeout_o`  out  1: one-cycle pulse coincident with an ack issued by timeout.

## Operation
- Reset values:
  - `ack_o`=0, `busy_o`=0, `owner_o`=0, `div_factor_o`=2, `timeout_o`=0.
  - Round-robin pointer = 0; state IDLE; previous-`clk_div_i` register = 0.
- Normalization of the latched factor F, giving N:
  - If F<2, N=2.
  - Otherwise N = F with bit 0 cleared (odd factors round down), matching the divider's half-period rounding.
- Arbitration:
  - Round-robin search starts at the pointer and wraps at NUM_REQ-1 → 0.
  - After an ack to requester k, the pointer becomes (k+1) mod NUM_REQ.
- States and transitions:
  - IDLE:
    - If any `req_i` bit is set, latch the winner index into `owner_o` and latch N → APPLY.
    - Otherwise stay in IDLE.
  - APPLY:
    - If N equals `div_factor_o`, go to ACK with no change.
    - Otherwise `div_factor_o`<=N, clear the toggle count and the timeout count, and go to SETTLE.
  - SETTLE:
    - A toggle is `clk_div_i` differing from its registered previous value.
    - After 2 toggles, go to ACK. The second toggle guarantees at least one full half-period under the new factor.
  - ACK:
    - `ack_o[owner_o]`=1 for this cycle only, advance the pointer, return to IDLE.
- Boundary conditions:
  - A requester that drops `req_i` mid-transaction is ignored: the transaction completes and the ack still pulses.
  - A request arriving during `busy_o` waits; the earliest grant is the cycle after ACK.
  - Multiple simultaneous requests: only the winner is serviced; the others stay pending.
  - `rst_i` asserted in any state: immediate return to reset values; no ack is issued for the aborted transaction.
  - `factor_i` changing during a transaction has no effect after the IDLE latch.

## Timing
- Grant latency: the request is seen high in IDLE at cycle t → APPLY at t+1.
- `div_factor_o` update: visible at t+2.
- Equal-factor request: ack at t+2 (IDLE → APPLY → ACK).
- Changed factor: ack one cycle after the cycle in which the second toggle is detected.
  - Worst case ≈ old_half + new_half + 3 cycles.
- `ack_o`, `timeout_o` and `busy_o` are registered outputs.

## Configuration
- `CLK_DIV_CTRL_TIMEOUT_EN` defined:
  - A counter runs in SETTLE.
  - If it reaches `TIMEOUT_CYCLES` before the second toggle, go to ACK and pulse `timeout_o` with `ack_o`.
  - `div_factor_o` keeps the new value.
- `CLK_DIV_CTRL_TIMEOUT_EN` undefined:
  - No counter exists; SETTLE waits indefinitely.
  - `timeout_o` is tied to 0.

## Test plan
- Single request: after reset, requester 1 requests factor 10 → `div_factor_o`=10 at t+2; `ack_o[1]` pulses after two `clk_div_i` toggles; `clk_div_i` half-period = 5 cycles thereafter.
- Normalization:
  - Factor 0 → ack, `div_factor_o` stays 2 (equal-factor path, ack at t+2).
  - Factor 7 → `div_factor_o`=6.
- Round robin: all 4 requesters request at once from reset with factors 4/6/8/10 → acks in order 0,1,2,3, one transaction at a time, `busy_o` high throughout each.
- Fairness wrap: after an ack to requester 3, requests from 0 and 3 together → 0 served first.
- Reset mid-SETTLE: assert `rst_i` during SETTLE → `div_factor_o`=2, `busy_o`=0, no ack; a re-request completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=16): hold `clk_div_i` constant → `ack_o` and `timeout_o` pulse together 16 cycles after SETTLE entry. With the macro off, no ack occurs within 1000 cycles.
